// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan controller: the blank pattern,
// segment bit positions and the active-low hex glyph table.
package seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Active-low a..g glyphs; entry 15 first so HEX_SEG[n] is the glyph for n.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return HEX_SEG[nibble];
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble-to-glyph decoder, active-low segments a..g.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = hex_to_seg(i_nibble);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Round-robin seven-segment scanner with a double-buffered frame that only
// commits at frame boundaries, plus one dark cycle at the start of each slot.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS = 8,
    parameter int DIV    = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [4*DIGITS-1:0]   wr_data,
    input  logic [DIGITS-1:0]     wr_blank,
    input  logic [DIGITS-1:0]     wr_dp,
    output logic [7:0]            seg_o,
    output logic [DIGITS-1:0]     an_o,
    output logic                  frame_o
);

    localparam int CNT_W = $clog2(DIV);
    localparam int IDX_W = $clog2(DIGITS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic [4*DIGITS-1:0] r_act_data;
    logic [DIGITS-1:0]   r_act_blank;
    logic [DIGITS-1:0]   r_act_dp;
    logic [4*DIGITS-1:0] r_pnd_data;
    logic [DIGITS-1:0]   r_pnd_blank;
    logic [DIGITS-1:0]   r_pnd_dp;
    logic                r_pending;
    logic                r_ready;
    logic [7:0]          r_seg;
    logic [DIGITS-1:0]   r_an;
    logic                r_frame;

    logic                w_slot_end;
    logic                w_boundary;
    logic                w_transfer;
    logic                w_commit;
    logic                w_pending_nxt;
    logic [3:0]          w_nibble;
    logic [6:0]          w_hex;
    logic [7:0]          w_seg_lit;
    logic [DIGITS-1:0]   w_an_sel;

    assign w_slot_end = (r_cnt == CNT_MAX);
    assign w_boundary = w_slot_end && (r_idx == IDX_MAX);
    assign w_transfer = wr_valid && r_ready;
    // A transfer needs pending low and a commit needs it high, so they never coincide.
    assign w_commit   = w_boundary && r_pending;

    always_comb begin
        w_pending_nxt = r_pending;
        if (w_transfer) begin
            w_pending_nxt = 1'b1;
        end else if (w_commit) begin
            w_pending_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_slot_end) begin
            r_cnt <= '0;
            r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pnd_data  <= '0;
            r_pnd_blank <= '0;
            r_pnd_dp    <= '0;
            r_act_data  <= '0;
            r_act_blank <= '1;
            r_act_dp    <= '0;
            r_pending   <= 1'b0;
            r_ready     <= 1'b0;
        end else begin
            if (w_transfer) begin
                r_pnd_data  <= wr_data;
                r_pnd_blank <= wr_blank;
                r_pnd_dp    <= wr_dp;
            end
            if (w_commit) begin
                r_act_data  <= r_pnd_data;
                r_act_blank <= r_pnd_blank;
                r_act_dp    <= r_pnd_dp;
            end
            r_pending <= w_pending_nxt;
            r_ready   <= ~w_pending_nxt;
        end
    end

    assign w_nibble = r_act_data[{r_idx, 2'b00} +: 4];

    seg_hex_decode u_hex (
        .i_nibble (w_nibble),
        .o_seg    (w_hex)
    );

    always_comb begin
        w_seg_lit         = SEG_BLANK;
        w_seg_lit[6:0]    = w_hex;
        w_seg_lit[SEG_DP] = ~r_act_dp[r_idx];
    end

    assign w_an_sel = ~(DIGITS'(1) << r_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg   <= SEG_BLANK;
            r_an    <= '1;
            r_frame <= 1'b0;
        end else begin
            r_frame <= w_boundary;
            if (r_cnt == '0) begin
                r_seg <= SEG_BLANK;
                r_an  <= '1;
            end else begin
                r_an  <= w_an_sel;
                r_seg <= r_act_blank[r_idx] ? SEG_BLANK : w_seg_lit;
            end
        end
    end

    assign seg_o    = r_seg;
    assign an_o     = r_an;
    assign frame_o  = r_frame;
    assign wr_ready = r_ready;

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed display controller that shares a single 8-bit seven-segment bus between `DIGITS` digit positions by scanning them round-robin. It accepts hex digit values from the encoder/status logic through a valid/ready handshake and double-buffers them. Updates commit only at frame boundaries, so a frame never shows a mix of old and new digits. It drives active-low segment and digit-select lines, and inserts one dead-time cycle at the start of every digit slot to suppress ghosting.

## Interface
- `DIGITS`, default 8: number of digit positions; 2..8.
- `DIV`, default 1000: clock cycles per digit slot; must be ≥ 2.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `wr_valid`  in  1  new display frame offered.
- `wr_ready`  out  1  controller can accept a frame.
- `wr_data`  in  4*DIGITS  hex nibble per digit; digit i = `[4i+3:4i]`.
- `wr_blank`  in  DIGITS  1 = digit i dark.
- `wr_dp`  in  DIGITS  1 = decimal point of digit i lit.
- `seg_o`  out  8  active-low segments; bit0..6 = a..g, bit7 = dp.
- `an_o`  out  DIGITS  active-low digit select, at most one bit low.
- `frame_o`  out  1  one-cycle pulse after each frame boundary.

## Operation
- **State registers:**
  - `cnt` (0..DIV-1) and `idx` (0..DIGITS-1).
  - Active set: `act_data`, `act_blank`, `act_dp`.
  - Pending set: `pnd_*` plus the `pending` flag.
- **Scan:**
  - `cnt` increments every cycle.
  - When `cnt == DIV-1`: `cnt` ← 0 and `idx` ← `idx+1`, with `idx` wrapping from DIGITS-1 to 0.
- **Frame boundary:** the cycle with `cnt == DIV-1 && idx == DIGITS-1`.
- **Handshake:**
  - `wr_ready = !pending`, registered as the pending flag's complement.
  - A transfer occurs on a cycle where `wr_valid && wr_ready`: `pnd_*` ← inputs and `pending` ← 1.
  - The source holds its data while `wr_ready` is 0.
- **Commit:**
  - On a frame boundary with `pending == 1`: `act_*` ← `pnd_*` and `pending` ← 0.
  - On a frame boundary with `pending == 0`: active state is unchanged.
- **Simultaneous transfer and boundary:**
  - A transfer requires `pending == 0`, so the commit decision uses the pre-edge flag and nothing commits.
  - The accepted data commits at the next boundary.
- **Output decode**, registered from current state:
  - If `cnt == 0` (dead time): `an_o` is all ones and `seg_o` = 8'hFF.
  - Otherwise, `an_o` = ~onehot(`idx`).
  - `seg_o` = 8'hFF if `act_blank[idx]`.
  - Else `seg_o` = hexdecode(`act_data[idx]`) with bit7 = ~`act_dp[idx]`.
- **Hex decode**, active-low, bit7 = 1:
  - 0 = C0, 1 = F9, 2 = A4, 3 = B0, 4 = 99, 5 = 92, 6 = 82, 7 = F8.
  - 8 = 80, 9 = 90, A = 88, b = 83, C = C6, d = A1, E = 86, F = 8E.
- **`frame_o`:** registered, high for exactly the cycle following each frame boundary.

## Timing
- **Reset values** (asynchronous; outputs take them immediately):
  - `cnt` = 0, `idx` = 0, `act_data` = 0, `act_blank` = all ones, `act_dp` = 0.
  - `pending` = 0, `pnd_*` = 0.
  - `seg_o` = 8'hFF, `an_o` = all ones, `frame_o` = 0, `wr_ready` = 0.
  - `wr_ready` rises on the first clock edge after `rst` falls.
- **Output latency:** `seg_o`/`an_o` lag (`cnt`, `idx`, `act_*`) by one cycle.
  - Each digit is driven for DIV-1 cycles per slot, preceded by 1 dark cycle.
- **Frame period:** DIGITS × DIV cycles. The first boundary is at cycle DIGITS×DIV-1 after reset release.
- **Commit-to-display latency:**
  - New data first appears on digit 0 at boundary + 2 cycles.
  - That is 1 cycle for `cnt` to leave 0, plus 1 cycle of output register.
- **Worst-case acceptance-to-display:** one frame + 2 cycles.
- **Reset mid-operation:** any pending frame is discarded, and the scan restarts at digit 0.

## Structure
- **Package `seg_pkg`:**
  - `SEG_BLANK` = 8'hFF.
  - 16-entry hex-to-segment constant table.
  - Segment bit-index constants.
- **Sub-module `seg_hex_decode`:** combinational, 4-bit nibble in, 7-bit active-low a..g out.
  - Instantiated once, on the `idx`-muxed nibble.
- Everything else (prescaler, index, buffers, handshake, output registers) is in `seg_scan_ctrl`.

## Test plan
All scenarios use `DIGITS` = 8, `DIV` = 4.

- **Reset:**
  - Stimulus: assert `rst` mid-slot, release, run 40 cycles with no write.
  - Required: outputs hold reset values immediately; `wr_ready` = 1 one cycle after release; `seg_o` = FF for the full first frame; `frame_o` pulses at cycle 32.
- **Basic write:**
  - Stimulus: write `wr_data` = 0x76543210, blank = 0, dp = 0 at cycle 5.
  - Required: `wr_ready` drops at cycle 6 and returns after the boundary at 31.
  - Next frame shows `an_o` = FE/`seg_o` = C0 for 3 cycles, then dark, then FD/F9, then FB/A4, and so on.
- **Back-pressure:**
  - Stimulus: hold `wr_valid` with a second frame 0xFFFFFFFF while pending.
  - Required: no transfer until `wr_ready` = 1 after commit; the first frame displays intact; the second commits at the following boundary.
- **Boundary collision:**
  - Stimulus: assert `wr_valid` exactly on the boundary cycle with `pending` = 0.
  - Required: accepted, not committed at this boundary; displayed only after the next boundary.
- **Blank and dp:**
  - Stimulus: `wr_blank` = 0x08, `wr_dp` = 0x01, data 0.
  - Required: digit 0 `seg_o` = 40; digit 3 `an_o` = F7 with `seg_o` = FF; others C0.
- **Reset during pending:**
  - Stimulus: write, then pulse `rst` before the boundary.
  - Required: pending frame lost; display dark; `wr_ready` = 1 after release.
